serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 94 +++++++++
 tb/tb_serial_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: operands captured on start, DIGIT bits summed
// per cycle through a registered carry; result presented with a one-cycle done.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  op_a, op_b, shreg, shreg_next;
  logic              c;
  logic [CW-1:0]     cnt;
  logic [DIGIT:0]    slice_sum;
  logic              msb_cin;
  logic              last, accept;

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign last   = (cnt == CW'(N - 1));
  assign accept = start && (state != RUN);

  // The single DIGIT-bit adder slice shared by every cycle of the operation.
  assign slice_sum  = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + (DIGIT+1)'(c);
  // Carry into the slice's top bit, recovered from that bit's sum and inputs.
  assign msb_cin    = slice_sum[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];
  assign shreg_next = (shreg >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the default assignment first guarantees no latch on any path.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all datapath registers are plain flops, so all take the async reset;
  // there is no memory array here that would be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      shreg    <= '0;
      Sum      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else if (accept) begin
      op_a  <= A;
      op_b  <= Sub ? ~B : B;
      c     <= Sub;
      cnt   <= '0;
      shreg <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      c     <= slice_sum[DIGIT];
      cnt   <= cnt + 1'b1;
      shreg <= shreg_next;
      if (last) begin
        Sum      <= shreg_next;
        Carry    <= slice_sum[DIGIT];
        Overflow <= msb_cin ^ slice_sum[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three instances (8/1, 8/4, 1/1) sharing
// clock and reset, checked against hand-computed expected values.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8, DIGIT=1
  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, carry8, ovf8;
  // WIDTH=8, DIGIT=4
  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0, sum4;
  logic       busy4, done4, carry4, ovf4;
  // WIDTH=1, DIGIT=1
  logic       start1 = 1'b0, sub1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       busy1, done1, carry1, ovf1;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .Sub(sub8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Sum(sum8), .Carry(carry8), .Overflow(ovf8));

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .Sub(sub4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .Sum(sum4), .Carry(carry4), .Overflow(ovf4));

  serial_adder #(.WIDTH(1), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .Sub(sub1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .Sum(sum1), .Carry(carry1), .Overflow(ovf1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start an 8/1 operation, wait for done, check latency and results.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sub, input logic [7:0] e_sum,
                      input logic e_carry, input logic e_ovf);
    int cyc;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sub8 = sub;
    @(negedge clk);
    start8 = 1'b0;
    check({tag, " busy"}, busy8, 1);
    cyc = 0;
    while (!done8 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, 8);
    check({tag, " sum"}, sum8, e_sum);
    check({tag, " carry"}, carry8, e_carry);
    check({tag, " ovf"}, ovf8, e_ovf);
    check({tag, " busy_at_done"}, busy8, 0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, done8, 0);
  endtask

  initial begin
    int cyc;
    int done_seen;
    logic [3:0] tt_sum;
    logic [3:0] tt_carry;

    #2;
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset sum", sum8, 0);
    check("reset carry", carry8, 0);
    check("reset ovf", ovf8, 0);
    #10 rst = 1'b0;

    run8("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run8("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);

    // start pulsed during RUN cycle 3 must be ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 3;
    while (!done8 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("ignore latency", cyc, 8);
    check("ignore sum", sum8, 8'h46);
    check("ignore carry", carry8, 0);
    repeat (10) @(negedge clk);
    check("ignore no_second_busy", busy8, 0);

    // back-to-back: second start sampled in the DONE cycle
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h20; b8 = 8'h30; sub8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b first sum", sum8, 8'h50);
    start8 = 1'b1; a8 = 8'h40; b8 = 8'h40;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b done_low", done8, 0);
    check("b2b busy_high", busy8, 1);
    cyc = 1;
    while (!done8 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) check("b2b sum_held", sum8, 8'h50);
    end
    check("b2b spacing", cyc, 9);
    check("b2b second sum", sum8, 8'h80);
    check("b2b second ovf", ovf8, 1);

    // asynchronous reset during RUN cycle 4
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h11; sub8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);
    check("rst sum", sum8, 0);
    check("rst carry", carry8, 0);
    check("rst ovf", ovf8, 0);
    #10 rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) done_seen++;
    end
    check("rst no_done", done_seen, 0);
    run8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // DIGIT=4: two cycles per operation
    @(negedge clk);
    start4 = 1'b1; a4 = 8'h9C; b4 = 8'h75; sub4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("d4 latency", cyc, 2);
    check("d4 sum", sum4, 8'h11);
    check("d4 carry", carry4, 1);
    check("d4 ovf", ovf4, 0);

    // WIDTH=1: half-adder truth table, index = {A,B}
    tt_sum   = 4'b0110;
    tt_carry = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start1 = 1'b1; a1 = 1'(i >> 1); b1 = 1'(i); sub1 = 1'b0;
      @(negedge clk);
      start1 = 1'b0;
      cyc = 0;
      while (!done1 && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check($sformatf("w1 latency %0d", i), cyc, 1);
      check($sformatf("w1 sum %0d", i), sum1, tt_sum[i]);
      check($sformatf("w1 carry %0d", i), carry1, tt_carry[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
